// File: rtl/dmem_wbuf_if.sv
// Data-memory port bundle: one combinational read port and one
// byte-lane store port with status flags.
interface dmem_wbuf_if #(
  parameter int AW = 7
);
  logic [AW-1:0] rd_addr0;
  logic [31:0]   rd_dout0;
  logic          we0;
  logic [AW-1:0] wr_addr0;
  logic [1:0]    wr_boff;
  logic [31:0]   wr_din0;
  logic [2:0]    wr_strb;
  logic          init_done;
  logic          wr_err;

  modport master (
    output rd_addr0,
    output we0,
    output wr_addr0,
    output wr_boff,
    output wr_din0,
    output wr_strb,
    input  rd_dout0,
    input  init_done,
    input  wr_err
  );

  modport slave (
    input  rd_addr0,
    input  we0,
    input  wr_addr0,
    input  wr_boff,
    input  wr_din0,
    input  wr_strb,
    output rd_dout0,
    output init_done,
    output wr_err
  );
endinterface

// File: rtl/dmem_wbuf.sv
// Word-organised data memory with a post-reset clear pass and a
// one-entry store buffer that forwards to same-address loads.
module dmem_wbuf #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input logic        clk,
  input logic        rst,
  dmem_wbuf_if.slave bus
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    mask;
  } wb_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] clr_cnt_nx;
  wb_t           wb;
  logic          err_q;

  logic [31:0]   mem [DEPTH];

  logic          run;
  logic          is_sb;
  logic          is_sh;
  logic          is_sw;
  logic          dec_ok;
  logic [3:0]    dec_mask;
  logic [31:0]   dec_data;
  logic          cap;
  logic          drop;

  logic [31:0]   arr_word;
  logic          hit;
  logic [31:0]   rd_word;

  assign run   = (state == RUN);
  assign is_sb = (bus.wr_strb == 3'b000);
  assign is_sh = (bus.wr_strb == 3'b001);
  assign is_sw = (bus.wr_strb == 3'b010);

  // Store decode: replicate data into every lane so the mask alone
  // selects which bytes land.
  always_comb begin
    dec_ok   = 1'b0;
    dec_mask = 4'b0000;
    dec_data = '0;
    unique case (1'b1)
      is_sb: begin
        dec_ok   = 1'b1;
        dec_mask = 4'b0001 << bus.wr_boff;
        dec_data = {4{bus.wr_din0[7:0]}};
      end
      is_sh: begin
        dec_ok   = ~bus.wr_boff[0];
        dec_mask = bus.wr_boff[1] ? 4'b1100 : 4'b0011;
        dec_data = {2{bus.wr_din0[15:0]}};
      end
      is_sw: begin
        dec_ok   = (bus.wr_boff == 2'b00);
        dec_mask = 4'b1111;
        dec_data = bus.wr_din0;
      end
      default: begin
        dec_ok = 1'b0;
      end
    endcase
  end

  assign cap  = run & bus.we0 & dec_ok;
  assign drop = bus.we0 & ~(run & dec_ok);

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    unique case (state)
      CLEAR: begin
        clr_cnt_nx = clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        state_nx = RUN;
      end
      default: begin
        state_nx = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      wb      <= '0;
      err_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      clr_cnt  <= clr_cnt_nx;
      wb.valid <= cap;
      if (cap) begin
        wb.addr <= bus.wr_addr0;
        wb.data <= dec_data;
        wb.mask <= dec_mask;
      end
      if (drop) begin
        err_q <= 1'b1;
      end
    end
  end

  // The array has no reset; its contents come only from the clear pass.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_cnt] <= '0;
    end else if (wb.valid) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.mask[b]) begin
          mem[wb.addr][8*b +: 8] <= wb.data[8*b +: 8];
        end
      end
    end
  end

  assign arr_word = mem[bus.rd_addr0];
  assign hit      = wb.valid & (bus.rd_addr0 == wb.addr);

  always_comb begin
    rd_word = arr_word;
    for (int b = 0; b < 4; b++) begin
      if (hit && wb.mask[b]) begin
        rd_word[8*b +: 8] = wb.data[8*b +: 8];
      end
    end
  end

  assign bus.rd_dout0  = run ? rd_word : 32'h0;
  assign bus.init_done = run;
  assign bus.wr_err    = err_q;

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: expected values are queued when the
// stimulus is driven and popped when the output is sampled.
module tb_dmem_wbuf;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dmem_wbuf_if #(.AW(AW)) bus ();

  dmem_wbuf #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_run  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          cyc;

  task automatic expect_val(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag, input logic [31:0] got);
    logic [31:0] e;
    n_run++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, got);
      return;
    end
    e = exp_q.pop_front();
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [1:0] off,
                    input logic [31:0] d, input logic [2:0] s);
    bus.we0      = 1'b1;
    bus.wr_addr0 = a;
    bus.wr_boff  = off;
    bus.wr_din0  = d;
    bus.wr_strb  = s;
  endtask

  task automatic idle();
    bus.we0 = 1'b0;
  endtask

  task automatic wait_init(output int c, input int err_at);
    c = 0;
    while (!bus.init_done && c < 400) begin
      if (c == err_at) wr(AW'(1), 2'b00, 32'hFFFF_FFFF, SW);
      else idle();
      if (c == 3) begin
        expect_val(32'h0);
        #1;
        pop_cmp("clear_rd_zero", bus.rd_dout0);
      end
      @(posedge clk);
      #1;
      c++;
    end
    idle();
  endtask

  initial begin
    bus.rd_addr0 = '0;
    bus.we0      = 1'b0;
    bus.wr_addr0 = '0;
    bus.wr_boff  = '0;
    bus.wr_din0  = '0;
    bus.wr_strb  = SB;

    // first reset, clean clear pass
    #1 rst = 1'b0;
    #2;
    expect_val(32'h0);
    pop_cmp("rst_init_done", bus.init_done);
    expect_val(32'h0);
    pop_cmp("rst_wr_err", bus.wr_err);
    step();
    rst = 1'b1;
    wait_init(cyc, -1);
    expect_val(32'd128);
    pop_cmp("init_cycles", cyc);
    expect_val(32'h0);
    pop_cmp("init_wr_err", bus.wr_err);
    for (int a = 0; a < DEPTH; a += 17) begin
      bus.rd_addr0 = AW'(a);
      expect_val(32'h0);
      #1;
      pop_cmp("init_word_zero", bus.rd_dout0);
    end
    bus.rd_addr0 = AW'(DEPTH - 1);
    expect_val(32'h0);
    #1;
    pop_cmp("init_last_zero", bus.rd_dout0);

    // SW then SB to word 5
    step();
    bus.rd_addr0 = AW'(5);
    wr(AW'(5), 2'b00, 32'hDEAD_BEEF, SW);
    expect_val(32'h0);
    #2;
    pop_cmp("sw_same_cycle", bus.rd_dout0);
    step();
    wr(AW'(5), 2'b10, 32'h0000_0011, SB);
    expect_val(32'hDEAD_BEEF);
    #2;
    pop_cmp("sw_next_cycle", bus.rd_dout0);
    step();
    idle();
    expect_val(32'hDE11_BEEF);
    #2;
    pop_cmp("sb_forward", bus.rd_dout0);
    step();
    expect_val(32'hDE11_BEEF);
    #2;
    pop_cmp("sb_commit", bus.rd_dout0);

    // back-to-back halfwords accumulate in word 9
    step();
    bus.rd_addr0 = AW'(9);
    wr(AW'(9), 2'b10, 32'h0000_ABCD, SH);
    step();
    wr(AW'(9), 2'b00, 32'h0000_1234, SH);
    expect_val(32'hABCD_0000);
    #2;
    pop_cmp("sh_hi", bus.rd_dout0);
    step();
    idle();
    expect_val(32'hABCD_1234);
    #2;
    pop_cmp("sh_accum", bus.rd_dout0);
    step();
    expect_val(32'hABCD_1234);
    #2;
    pop_cmp("sh_accum_commit", bus.rd_dout0);

    // misaligned and illegal stores to word 3 are dropped
    expect_val(32'h0);
    pop_cmp("err_before", bus.wr_err);
    bus.rd_addr0 = AW'(3);
    wr(AW'(3), 2'b00, 32'h0000_0077, SB);
    step();
    idle();
    step();
    expect_val(32'h0000_0077);
    pop_cmp("sb3", bus.rd_dout0);
    wr(AW'(3), 2'b01, 32'h0000_FFFF, SH);
    step();
    idle();
    step();
    expect_val(32'h1);
    pop_cmp("err_sh_misalign", bus.wr_err);
    expect_val(32'h0000_0077);
    pop_cmp("sh_misalign_drop", bus.rd_dout0);
    wr(AW'(3), 2'b10, 32'hFFFF_FFFF, SW);
    step();
    idle();
    step();
    expect_val(32'h0000_0077);
    pop_cmp("sw_misalign_drop", bus.rd_dout0);
    wr(AW'(3), 2'b00, 32'hFFFF_FFFF, 3'b011);
    step();
    idle();
    step();
    expect_val(32'h0000_0077);
    pop_cmp("strb_illegal_drop", bus.rd_dout0);
    expect_val(32'h1);
    pop_cmp("err_sticky", bus.wr_err);

    // reset mid-run, store attempted during the clear pass
    bus.rd_addr0 = AW'(5);
    rst = 1'b0;
    #2;
    expect_val(32'h0);
    pop_cmp("rst2_init_done", bus.init_done);
    expect_val(32'h0);
    pop_cmp("rst2_wr_err", bus.wr_err);
    expect_val(32'h0);
    pop_cmp("rst2_rd_zero", bus.rd_dout0);
    step();
    rst = 1'b1;
    wait_init(cyc, 10);
    expect_val(32'd128);
    pop_cmp("clear_write_cycles", cyc);
    expect_val(32'h1);
    pop_cmp("clear_write_err", bus.wr_err);
    expect_val(32'h0);
    pop_cmp("rst2_word5_zero", bus.rd_dout0);
    bus.rd_addr0 = AW'(1);
    expect_val(32'h0);
    #1;
    pop_cmp("clear_write_ignored", bus.rd_dout0);

    // reset with a buffered store pending
    step();
    wr(AW'(7), 2'b00, 32'h55AA_55AA, SW);
    step();
    idle();
    bus.rd_addr0 = AW'(7);
    expect_val(32'h55AA_55AA);
    #2;
    pop_cmp("w7_forward", bus.rd_dout0);
    #1;
    rst = 1'b0;
    #1;
    expect_val(32'h0);
    pop_cmp("rst3_wr_err", bus.wr_err);
    step();
    rst = 1'b1;
    wait_init(cyc, -1);
    expect_val(32'd128);
    pop_cmp("rst3_cycles", cyc);
    expect_val(32'h0);
    pop_cmp("rst3_word7_zero", bus.rd_dout0);
    step();
    expect_val(32'h0);
    pop_cmp("rst3_word7_stay", bus.rd_dout0);
    expect_val(32'h0);
    pop_cmp("rst3_err_zero", bus.wr_err);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
